// File: rtl/vector_pkg.sv
// vector_pkg: shared opcodes, vtype field layout, issue-entry format and FSM states.
package vector_pkg;
  localparam logic [6:0] OP_VL = 7'h07;
  localparam logic [6:0] OP_VS = 7'h27;
  localparam logic [6:0] OP_V = 7'h57;
  localparam logic [2:0] FUNCT3_CFG = 3'b111;
  localparam int VT_W = 11;
  localparam int VSEW_LSB = 3;
  localparam int VLMUL_LSB = 0;
  localparam int VT_RSV_LSB = 6;
  typedef struct packed {
    logic [6:0] opcode;
    logic [5:0] funct6;
    logic [2:0] funct3;
    logic [4:0] vs1a;
    logic [4:0] vs2a;
    logic [4:0] vs3a;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [10:0] sew;
    logic [3:0] lmul;
    logic [31:0] vl;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
  typedef enum logic [1:0] {IDLE, WAIT1, WAITB} state_e;
  function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/vector_issue_fifo.sv
// vector_issue_fifo: DEPTH-entry instruction queue; a pop frees the head slot for a same-cycle push.
module vector_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/vector_issue.sv
// vector_issue: executes vset{i}vl{i} locally and queues/issues other vector instructions
// one at a time to the execute stage.
module vector_issue
  import vector_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_rd_we,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [6:0]  o_ops,
  output logic [5:0]  o_funct6,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2,
  output logic [4:0]  o_vs1a,
  output logic [4:0]  o_vs2a,
  output logic [4:0]  o_vs3a,
  output logic [10:0] o_sew,
  output logic [3:0]  o_lmul,
  output logic [31:0] o_venum,
  input  logic        i_ex_busy,
  output logic        o_vill,
  output logic        o_empty
);
  state_e state_q;
  logic vill_q, rd_we_q, fire_q;
  logic [2:0] vsew_q, vlmul_q;
  logic [31:0] vl_q;
  logic [4:0] rd_addr_q;
  entry_t iss_q, wr_e, rd_e;
  logic [6:0] opc;
  logic [4:0] rs1f, rdf;
  logic cfg, is_vli, is_ivli, is_vl, cfg_we, vec, legal, push, pop, acc, full, fifo_empty;
  logic [VT_W-1:0] vt;
  logic [2:0] nsew, nlmul;
  logic [31:0] vlmax, avl, vl_new;
  logic [10:0] new_sew;
  logic [3:0] new_lmul;
  logic unused_vm;
  assign unused_vm = i_instr[25];
  assign opc = i_instr[6:0];
  assign rs1f = i_instr[19:15];
  assign rdf = i_instr[11:7];
  assign cfg = opc == OP_V && i_instr[14:12] == FUNCT3_CFG;
  assign is_vli = cfg && !i_instr[31];
  assign is_ivli = cfg && i_instr[31:30] == 2'b11;
  assign is_vl = cfg && i_instr[31:25] == 7'b1000000;
  assign vec = (opc == OP_VL || opc == OP_VS || opc == OP_V) && !cfg;
  assign vt = is_vl ? i_rs2[VT_W-1:0] : is_ivli ? {1'b0, i_instr[29:20]} : i_instr[30:20];
  assign nsew = vt[VSEW_LSB+:3];
  assign nlmul = vt[VLMUL_LSB+:3];
  // Fractional LMUL and SEW above 64 are reported as vill rather than supported.
  assign legal = vt[VT_W-1:VT_RSV_LSB] == '0 && !nsew[2] && !nlmul[2];
  assign vlmax = (32'(VLEN) << nlmul) >> (4'(nsew) + 4'd3);
  assign avl = is_ivli ? 32'(rs1f) : i_rs1;
  always_comb begin
    vl_new = !legal ? 32'd0 : (is_ivli || rs1f != 5'd0) ? umin(avl, vlmax) : (rdf != 5'd0) ? vlmax : umin(vl_q, vlmax);
    new_sew = legal ? 11'd8 << nsew : 11'd0;
    new_lmul = legal ? (4'd1 << nlmul) - 4'd1 : 4'd0;
  end
  assign o_ready = rst && (!full || pop || !vec);
  assign acc = i_valid && o_ready;
  assign cfg_we = acc && (is_vli || is_ivli || is_vl);
  assign push = acc && vec && !vill_q;
  assign pop = state_q == IDLE && !fifo_empty && !i_ex_busy;
  assign wr_e = '{opcode: opc, funct6: i_instr[31:26], funct3: i_instr[14:12], vs1a: rs1f,
                  vs2a: i_instr[24:20], vs3a: rdf, rs1: i_rs1, rs2: i_rs2,
                  sew: 11'd8 << vsew_q, lmul: (4'd1 << vlmul_q) - 4'd1, vl: vl_q};
  vector_issue_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .wdata_i(wr_e),
    .pop_i(pop),
    .rdata_o(rd_e),
    .full_o(full),
    .empty_o(fifo_empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      vill_q <= 1'b1;
      vsew_q <= '0;
      vlmul_q <= '0;
      vl_q <= '0;
      rd_we_q <= 1'b0;
      rd_addr_q <= '0;
      fire_q <= 1'b0;
      iss_q <= '0;
    end else begin
      rd_we_q <= cfg_we;
      fire_q <= pop;
      if (cfg_we) begin
        vill_q <= !legal;
        vsew_q <= legal ? nsew : 3'd0;
        vlmul_q <= legal ? nlmul : 3'd0;
        vl_q <= vl_new;
        rd_addr_q <= rdf;
      end
      state_q <= pop ? WAIT1 : state_q == WAIT1 ? WAITB : (state_q == WAITB && !i_ex_busy) ? IDLE : state_q;
      // With nothing queued or executing, the data ports track the live config.
      if (pop) iss_q <= rd_e;
      else if (cfg_we && o_empty) begin
        iss_q.sew <= new_sew;
        iss_q.lmul <= new_lmul;
        iss_q.vl <= vl_new;
      end
    end
  assign o_rd_we = rd_we_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = vl_q;
  assign o_ops = fire_q ? iss_q.opcode : 7'h00;
  assign o_funct6 = iss_q.funct6;
  assign o_funct3 = iss_q.funct3;
  assign o_rs1 = iss_q.rs1;
  assign o_rs2 = iss_q.rs2;
  assign o_vs1a = iss_q.vs1a;
  assign o_vs2a = iss_q.vs2a;
  assign o_vs3a = iss_q.vs3a;
  assign o_sew = iss_q.sew;
  assign o_lmul = iss_q.lmul;
  assign o_venum = iss_q.vl;
  assign o_vill = vill_q;
  assign o_empty = fifo_empty && state_q == IDLE;
endmodule

// File: tb/tb_vector_issue.sv
// tb_vector_issue: directed vectors with hand-computed expectations for vector_issue (VLEN=128, DEPTH=4).
module tb_vector_issue;
  logic clk = 0, rst = 0, i_valid = 0, i_ex_busy = 0;
  logic [31:0] i_instr = 0, i_rs1 = 0, i_rs2 = 0;
  logic o_ready, o_rd_we, o_vill, o_empty;
  logic [4:0] o_rd_addr, o_vs1a, o_vs2a, o_vs3a;
  logic [31:0] o_rd_data, o_rs1, o_rs2, o_venum;
  logic [6:0] o_ops;
  logic [5:0] o_funct6;
  logic [2:0] o_funct3;
  logic [10:0] o_sew;
  logic [3:0] o_lmul;
  int tests = 0, fails = 0;

  vector_issue #(.VLEN(128), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .o_rd_we(o_rd_we), .o_rd_addr(o_rd_addr),
    .o_rd_data(o_rd_data), .o_ops(o_ops), .o_funct6(o_funct6), .o_funct3(o_funct3),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_vs1a(o_vs1a), .o_vs2a(o_vs2a), .o_vs3a(o_vs3a),
    .o_sew(o_sew), .o_lmul(o_lmul), .o_venum(o_venum), .i_ex_busy(i_ex_busy),
    .o_vill(o_vill), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input string tag);
    i_valid = 1;
    i_instr = ins;
    i_rs1 = r1;
    i_rs2 = r2;
    #1;
    chk(tag, o_ready, 1);
    step();
    i_valid = 0;
  endtask

  function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] vt);
    return {1'b0, vt, rs1, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] vt);
    return {2'b11, vt, uimm, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vadd(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
    return {6'd0, 1'b1, vs2, vs1, 3'b000, vd, 7'h57};
  endfunction
  function automatic logic [31:0] vle(input logic [4:0] vd);
    return {12'h020, 5'd10, 3'b110, vd, 7'h07};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ops", o_ops, 0);
    chk("rst_rd_we", o_rd_we, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_sew", o_sew, 0);
    chk("rst_lmul", o_lmul, 0);
    chk("rst_venum", o_venum, 0);
    chk("rst_funct6", o_funct6, 0);
    chk("rst_rs1", o_rs1, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_vill", o_vill, 1);
    chk("rst_empty", o_empty, 1);
    rst = 1;
    step();
    // vsetvli x5, x1(=100), e32, m2 -> VLMAX 8
    offer(vsetvli(5, 1, 11'h011), 100, 0, "t1_ready");
    chk("t1_rd_we", o_rd_we, 1);
    chk("t1_rd_addr", o_rd_addr, 5);
    chk("t1_rd_data", o_rd_data, 8);
    chk("t1_sew", o_sew, 32);
    chk("t1_lmul", o_lmul, 1);
    chk("t1_venum", o_venum, 8);
    chk("t1_vill", o_vill, 0);
    step();
    chk("t1_rd_we_pulse", o_rd_we, 0);
    // rs1=x0, rd=x0, e64 m1: keep vl, clipped to VLMAX 2
    offer(vsetvli(0, 0, 11'h018), 0, 0, "t5_ready");
    chk("t5_rd_we", o_rd_we, 1);
    chk("t5_rd_addr", o_rd_addr, 0);
    chk("t5_rd_data", o_rd_data, 2);
    chk("t5_sew", o_sew, 64);
    chk("t5_lmul", o_lmul, 0);
    // vsetivli x0, 3, e8 m1 then two vadds
    offer(vsetivli(0, 3, 10'h000), 0, 0, "t2_cfg_ready");
    chk("t2_rd_we", o_rd_we, 1);
    chk("t2_rd_data", o_rd_data, 3);
    offer(vadd(3, 1, 2), 32'h11, 32'h22, "t2_add1_ready");
    chk("t2_no_issue_yet", o_ops, 0);
    chk("t2_not_empty", o_empty, 0);
    step();
    chk("t2_ops", o_ops, 7'h57);
    chk("t2_venum", o_venum, 3);
    chk("t2_sew", o_sew, 8);
    chk("t2_lmul", o_lmul, 0);
    chk("t2_vs1a", o_vs1a, 1);
    chk("t2_vs2a", o_vs2a, 2);
    chk("t2_vs3a", o_vs3a, 3);
    chk("t2_rs1", o_rs1, 32'h11);
    chk("t2_rs2", o_rs2, 32'h22);
    i_ex_busy = 1;
    offer(vadd(9, 4, 5), 0, 0, "t2_add2_ready");
    chk("t2_pulse_one_cycle", o_ops, 0);
    step();
    chk("t2_held_busy_a", o_ops, 0);
    step();
    chk("t2_held_busy_b", o_ops, 0);
    chk("t2_data_stable", o_vs3a, 3);
    i_ex_busy = 0;
    step();
    chk("t2_back_idle", o_ops, 0);
    step();
    chk("t2_add2_ops", o_ops, 7'h57);
    chk("t2_add2_vs3a", o_vs3a, 9);
    step();
    chk("t2_add2_pulse", o_ops, 0);
    step();
    chk("t2_drained", o_empty, 1);
    // fill with four loads while busy
    i_ex_busy = 1;
    for (int k = 0; k < 4; k++) offer(vle(5'(4 + k)), 0, 0, "t3_fill_ready");
    i_valid = 1;
    i_instr = vle(8);
    #1;
    chk("t3_full_ready", o_ready, 0);
    offer(vsetvli(6, 1, 11'h011), 4, 0, "t3_cfg_when_full");
    chk("t3_cfg_rd_we", o_rd_we, 1);
    chk("t3_cfg_rd_addr", o_rd_addr, 6);
    chk("t3_cfg_rd_data", o_rd_data, 4);
    chk("t3_sew_stable", o_sew, 8);
    chk("t3_venum_stable", o_venum, 3);
    i_ex_busy = 0;
    i_valid = 1;
    i_instr = vle(8);
    #1;
    chk("t3_pop_frees_slot", o_ready, 1);
    step();
    i_valid = 0;
    chk("t3_l0_ops", o_ops, 7'h07);
    chk("t3_l0_vs3a", o_vs3a, 4);
    chk("t3_l0_venum", o_venum, 3);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("t3_gap", o_ops, 0);
      step();
      step();
      chk("t3_ops", o_ops, 7'h07);
      chk("t3_vs3a", o_vs3a, 32'(4 + k));
      chk("t3_venum", o_venum, (k == 4) ? 32'd4 : 32'd3);
      chk("t3_sew", o_sew, (k == 4) ? 32'd32 : 32'd8);
    end
    step();
    step();
    chk("t3_drained", o_empty, 1);
    // vsetvl with vsew=7 -> illegal
    offer(vsetvl(7, 1, 2), 5, 32'h03C, "t4_ready");
    chk("t4_rd_we", o_rd_we, 1);
    chk("t4_rd_addr", o_rd_addr, 7);
    chk("t4_rd_data", o_rd_data, 0);
    chk("t4_vill", o_vill, 1);
    offer(vadd(1, 2, 3), 0, 0, "t4_add_ready");
    chk("t4_dropped_empty", o_empty, 1);
    step();
    chk("t4_no_issue", o_ops, 0);
    chk("t4_still_empty", o_empty, 1);
    // reset in WAITB with two entries queued
    offer(vsetvli(5, 1, 11'h011), 100, 0, "t6_cfg_ready");
    chk("t6_vill", o_vill, 0);
    chk("t6_rd_data", o_rd_data, 8);
    offer(vadd(1, 1, 1), 0, 0, "t6_add1_ready");
    offer(vadd(2, 2, 2), 0, 0, "t6_add2_ready");
    chk("t6_issue", o_ops, 7'h57);
    chk("t6_venum", o_venum, 8);
    i_ex_busy = 1;
    offer(vadd(3, 3, 3), 0, 0, "t6_add3_ready");
    step();
    chk("t6_waitb", o_ops, 0);
    chk("t6_busy_not_empty", o_empty, 0);
    rst = 0;
    #1;
    chk("t6_rst_empty", o_empty, 1);
    chk("t6_rst_vill", o_vill, 1);
    chk("t6_rst_ops", o_ops, 0);
    chk("t6_rst_venum", o_venum, 0);
    chk("t6_rst_sew", o_sew, 0);
    chk("t6_rst_rd_data", o_rd_data, 0);
    rst = 1;
    i_ex_busy = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_issue", o_ops, 0);
      chk("t6_empty", o_empty, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
